fold_sequencer: RTL

Transmit side of the folded fusion interface. Accepts one full encoded hypervector per modality, buffers it, and streams it as `NUM_FOLDS` slices of `FOLD_WIDTH` bits with a matching `fold_counter`. After the last slice of the last modality it raises `done` so the downstream majority fuser can publish and clear. It sits between the per-modality spatial encoders and the fuser.

---
 rtl/fold_sequencer_if.sv | 41 ++++
 rtl/fold_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/fold_sequencer_if.sv
// fold_sequencer_if: hypervector input, fold stream output and done handshake
// between the spatial encoders, the fold sequencer and the fuser.
interface fold_sequencer_if #(
  parameter int HV_DIMENSION    = 2000,
  parameter int FOLD_WIDTH      = 500,
  parameter int NUM_FOLDS_WIDTH = 2
);
  logic                       hvin_valid;
  logic                       hvin_ready;
  logic [HV_DIMENSION-1:0]    hvin;
  logic                       fold_valid;
  logic                       fold_ready;
  logic [FOLD_WIDTH-1:0]      fold_hv;
  logic [NUM_FOLDS_WIDTH-1:0] fold_counter;
  logic                       done;
  logic                       done_ready;

  modport master (
    input  hvin_valid,
    input  hvin,
    input  fold_ready,
    input  done_ready,
    output hvin_ready,
    output fold_valid,
    output fold_hv,
    output fold_counter,
    output done
  );

  modport slave (
    output hvin_valid,
    output hvin,
    output fold_ready,
    output done_ready,
    input  hvin_ready,
    input  fold_valid,
    input  fold_hv,
    input  fold_counter,
    input  done
  );
endinterface

// File: rtl/fold_sequencer.sv
// fold_sequencer: buffers one hypervector per modality and streams it as
// NUM_FOLDS slices; raises done after the last slice of the last modality.
module fold_sequencer #(
  parameter int NUM_FOLDS       = 4,
  parameter int NUM_FOLDS_WIDTH = 2,
  parameter int FOLD_WIDTH      = 500,
  parameter int HV_DIMENSION    = 2000,
  parameter int NUM_MODALITY    = 3
) (
  input logic             clk,
  input logic             rst,
  fold_sequencer_if.master bus
);
  localparam int MW = (NUM_MODALITY > 1) ? $clog2(NUM_MODALITY) : 1;
  localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD =
    NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);
  localparam logic [MW-1:0] LAST_MOD = MW'(NUM_MODALITY - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [HV_DIMENSION-1:0]    buf_q, buf_d;
  logic [NUM_FOLDS_WIDTH-1:0] fold_q, fold_d;
  logic [MW-1:0]              mod_q, mod_d;

  logic hvin_ready;
  logic fold_valid;
  logic done;
  logic last_fold;
  logic last_mod;
  int   sel;

  assign last_fold = (fold_q == LAST_FOLD);
  assign last_mod  = (mod_q == LAST_MOD);
  assign sel       = int'(fold_q) * FOLD_WIDTH;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    fold_d     = fold_q;
    mod_d      = mod_q;
    hvin_ready = 1'b0;
    fold_valid = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        hvin_ready = 1'b1;
        if (bus.hvin_valid) begin
          buf_d   = bus.hvin;
          fold_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        fold_valid = 1'b1;
        if (bus.fold_ready) begin
          if (!last_fold) begin
            fold_d = fold_q + NUM_FOLDS_WIDTH'(1);
          end else begin
            fold_d = '0;
            if (last_mod) begin
              state_d = DONE;
            end else begin
              // next modality may be captured on the closing beat
              mod_d      = mod_q + MW'(1);
              hvin_ready = 1'b1;
              if (bus.hvin_valid) begin
                buf_d = bus.hvin;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (bus.done_ready) begin
          state_d = IDLE;
          mod_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      fold_q  <= '0;
      mod_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fold_q  <= fold_d;
      mod_q   <= mod_d;
    end
  end

  assign bus.hvin_ready   = hvin_ready;
  assign bus.fold_valid   = fold_valid;
  assign bus.done         = done;
  assign bus.fold_counter = fold_q;
  assign bus.fold_hv      = buf_q[sel +: FOLD_WIDTH];
endmodule
